fifo_serializer: RTL

- Parametrised successor to the team's byte FIFO plus bit-serial output stage.
- Buffers DATA_W-bit words in a 2**ADDR_W-deep FIFO with a valid/ready write port.
- Serialises each word onto LANES parallel output lanes, in LSB-first or MSB-first order.
- Streams back-to-back words without bubbles; sits between a word-oriented producer and a narrow serial link.

---
 rtl/fifo_ser_pkg.sv | 23 ++
 rtl/fifo_core.sv | 73 +++++++
 rtl/fifo_serializer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_ser_pkg.sv
// fifo_ser_pkg
// Shared types and elaboration helpers for the FIFO serialiser.
//   ser_state_e    : serialiser FSM states (IDLE, SHIFT)
//   beat_cnt_width : width of the beat counter for a given number of beats
//   lanes_fit      : legality check that a word splits evenly into lanes
package fifo_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // A single-beat word still needs a 1-bit counter so the FSM logic
    // keeps the same shape for every configuration.
    function automatic int beat_cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    function automatic bit lanes_fit(input int data_w, input int lanes);
        return (lanes > 0) && ((data_w % lanes) == 0);
    endfunction

endpackage

// File: rtl/fifo_core.sv
// fifo_core
// Word FIFO of 2**ADDR_W entries with wrap-bit pointers.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write request (ignored while full)
//   pop_i      : read request (ignored while empty)
//   wr_data_i  : word to write
//   rd_data_o  : mem[rd_ptr], unregistered view of the head word
//   count_o    : number of stored words
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
module fifo_core
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              do_push;
    logic              do_pop;

    // The top pointer bit records how many times each pointer has wrapped;
    // equal addresses with different wrap bits mean the writer is a full
    // lap ahead of the reader.
    assign full_o  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rd_data_o = mem[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Storage is deliberately left out of reset; the pointers alone define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer
// Buffers DATA_W-bit words and streams each one out as BEATS = DATA_W/LANES
// slices of LANES bits, LSB-first or MSB-first, with no bubble between
// consecutive words.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : write word
//   in_valid   : write request; accepted when in_ready is high
//   in_ready   : FIFO not full
//   rd_en      : allows the serialiser to start a new word
//   out_data   : current slice, zero when out_valid is low
//   out_valid  : out_data carries a valid slice
//   out_last   : final slice of the current word
//   count      : words waiting in the FIFO (excludes the word being sent)
//   full/empty : FIFO status
module fifo_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rd_en,
    output logic [LANES-1:0]  out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int BEATS = DATA_W / LANES;
    localparam int CNT_W = beat_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!lanes_fit(DATA_W, LANES)) begin : g_bad_lanes
        $error("fifo_serializer: DATA_W must be a multiple of LANES");
    end

    ser_state_e        state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] head_word;
    logic              pop;
    logic              can_pop;
    logic              last_beat;
    logic [CNT_W-1:0]  slice_sel;
    logic [LANES-1:0]  slices [BEATS];

    fifo_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .push_i    (in_valid),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (head_word),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign in_ready  = ~full;
    assign can_pop   = rd_en && !empty;
    assign last_beat = (state_q == SHIFT) && (beat_q == LAST_BEAT);

    // Next-state logic. A new word is loaded either from IDLE or on the
    // last beat of the current word, which is what removes the bubble.
    // rd_en only gates loading; a word in flight always completes.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    word_d  = head_word;
                    beat_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_beat) begin
                    beat_d = '0;
                    if (can_pop) begin
                        pop    = 1'b1;
                        word_d = head_word;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

    for (genvar b = 0; b < BEATS; b++) begin : g_slice
        assign slices[b] = word_q[b*LANES +: LANES];
    end

    // MSB-first walks the slice table backwards from the top slice.
    assign slice_sel = (MSB_FIRST != 0) ? (LAST_BEAT - beat_q) : beat_q;

    assign out_valid = (state_q == SHIFT);
    assign out_last  = last_beat;
    assign out_data  = out_valid ? slices[slice_sel] : '0;

endmodule
